// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch front-end widths, reset PC and the fetch entry layout
package core_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam int          DEF_ILEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer holding fetched {pc, instruction} entries
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the indices coincide.
    assign count      = wr_ptr - rd_ptr;
    assign head_valid = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = pop && head_valid && !clear;
    assign do_push    = push && !clear && (!full || do_pop);
    assign head_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner, credit-limited imem requester and decode-side fetch buffer
module fetch_queue
    import core_pkg::*;
#(
    parameter int               XLEN     = DEF_XLEN,
    parameter int               ILEN     = DEF_ILEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int               PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [ILEN-1:0]            imem_rdata,
    output logic                       fetch_valid,
    output logic [XLEN+ILEN-1:0]       fetch_data,
    input  logic                       fetch_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW:0]     demand;
    logic            credit_ok;

    // Buffered plus outstanding fetches must fit, so a returning response always finds room.
    assign demand    = {1'b0, occupancy} + (CW+1)'(inflight);
    assign credit_ok = demand < (CW+1)'(DEPTH);
    assign imem_req  = !reset && !stall && !redirect_valid && credit_ok;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= pc + XLEN'(PC_STEP);
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .push       (inflight && !redirect_valid),
        .push_data  ({inflight_pc, imem_rdata}),
        .pop        (fetch_valid && fetch_ready),
        .head_valid (fetch_valid),
        .head_data  (fetch_data),
        .count      (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!reset) assert (occupancy <= CW'(DEPTH));
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        fetch_valid;
    logic [63:0] fetch_data;
    logic        fetch_ready = 1'b0;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_req_cyc = -1;
    int first_val_cyc = -1;
    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_ins_q[$];

    fetch_queue #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_req) imem_rdata <= instr_of(imem_addr);
    end

    always @(negedge clk) begin
        fetch_entry_t ent;
        ent = fetch_data;
        if (!reset) begin
            if (imem_req) begin
                req_q.push_back(imem_addr);
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (fetch_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (fetch_valid && fetch_ready && !redirect_valid) begin
                pop_pc_q.push_back(ent.pc);
                pop_ins_q.push_back(ent.instr);
            end
        end
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
        first_req_cyc = -1;
        first_val_cyc = -1;
    endtask

    task automatic do_reset(input logic ready);
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        fetch_ready = ready;
        tick(2);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_occ(input int target, input string tag);
        int n;
        n = 0;
        while (32'(occupancy) != target && n < 20) begin
            tick();
            n++;
        end
        expect_eq(tag, 64'(occupancy), 64'(target));
    endtask

    initial begin
        // reset state
        tick(2);
        expect_eq("rst_req", 64'(imem_req), 64'd0);
        expect_eq("rst_valid", 64'(fetch_valid), 64'd0);
        expect_eq("rst_occ", 64'(occupancy), 64'd0);
        expect_eq("rst_addr", 64'(imem_addr), 64'h0);

        // 1: streaming with decode always ready
        do_reset(1'b1);
        tick(8);
        for (int i = 0; i < 3; i++) expect_eq("t1_addr", 64'(req_q[i]), 64'(4 * i));
        expect_eq("t1_latency", 64'(first_val_cyc - first_req_cyc), 64'd2);
        expect_eq("t1_npop", 64'(pop_pc_q.size()), 64'd6);
        for (int i = 0; i < 4; i++) begin
            expect_eq("t1_pc", 64'(pop_pc_q[i]), 64'(4 * i));
            expect_eq("t1_ins", 64'(pop_ins_q[i]), 64'(instr_of(32'(4 * i))));
        end

        // 2: backpressure fills to DEPTH, then drains in order
        do_reset(1'b0);
        tick(8);
        expect_eq("t2_nreq", 64'(req_q.size()), 64'd4);
        expect_eq("t2_occ", 64'(occupancy), 64'd4);
        expect_eq("t2_req_off", 64'(imem_req), 64'd0);
        fetch_ready = 1'b1;
        tick(8);
        for (int i = 0; i < 4; i++) expect_eq("t2_pc", 64'(pop_pc_q[i]), 64'(4 * i));
        expect_eq("t2_resume", 64'(req_q[4]), 64'h10);

        // 3: redirect with 3 buffered and one in flight
        do_reset(1'b0);
        wait_occ(3, "t3_fill");
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        fetch_ready = 1'b1;
        #1;
        expect_eq("t3_req_off", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        fetch_ready = 1'b0;
        #1;
        expect_eq("t3_occ", 64'(occupancy), 64'd0);
        expect_eq("t3_valid", 64'(fetch_valid), 64'd0);
        expect_eq("t3_addr", 64'(imem_addr), 64'h100);
        expect_eq("t3_req", 64'(imem_req), 64'd1);
        fetch_ready = 1'b1;
        tick(4);
        expect_eq("t3_first_pc", 64'(pop_pc_q[0]), 64'h100);

        // 4: stall mid-stream
        do_reset(1'b1);
        tick(4);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            expect_eq("t4_req_off", 64'(imem_req), 64'd0);
            tick();
        end
        expect_eq("t4_drained", 64'(occupancy), 64'd0);
        stall = 1'b0;
        tick(6);
        expect_eq("t4_nreq", 64'(req_q.size()), 64'd10);
        expect_eq("t4_npop", 64'(pop_pc_q.size()), 64'd8);
        foreach (req_q[i]) expect_eq("t4_addr_seq", 64'(req_q[i]), 64'(4 * i));
        foreach (pop_pc_q[i]) expect_eq("t4_pop_seq", 64'(pop_pc_q[i]), 64'(4 * i));

        // 5: PC wrap
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        expect_eq("t5_addr_top", 64'(imem_addr), 64'hFFFF_FFFC);
        expect_eq("t5_req", 64'(imem_req), 64'd1);
        tick();
        expect_eq("t5_wrap", 64'(imem_addr), 64'h0);

        // 6: reset in the middle of a stream
        do_reset(1'b0);
        wait_occ(2, "t6_fill");
        reset = 1'b1;
        #1;
        expect_eq("t6_valid", 64'(fetch_valid), 64'd0);
        expect_eq("t6_occ", 64'(occupancy), 64'd0);
        expect_eq("t6_addr", 64'(imem_addr), 64'h0);
        expect_eq("t6_req", 64'(imem_req), 64'd0);
        tick();
        reset = 1'b0;
        clear_logs();
        fetch_ready = 1'b1;
        tick(5);
        expect_eq("t6_restart_addr", 64'(req_q[0]), 64'h0);
        expect_eq("t6_restart_pc", 64'(pop_pc_q[0]), 64'h0);
        expect_eq("t6_restart_ins", 64'(pop_ins_q[0]), 64'(instr_of(32'h0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
